calc_core: RTL and testbench

Parametrised four-function integer calculator core: the second generation of the board calculator. It sits between `keyboard` (consumes its one-cycle `key_pulse`) and `led_segment` (drives its digit codes). Compared with the first generation it adds:
- configurable operand length and display width;
- full `+ - * /` with signed results;
- multi-cycle division and binary-to-BCD conversion, with a busy flag;
- result chaining and divide-by-zero/overflow error handling.

---
 rtl/calc_pkg.sv | 85 ++++++++
 rtl/calc_div.sv | 91 +++++++++
 rtl/calc_core.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_calc_core.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator core.
//   - key-bit indices of the one-hot key_pulse bus
//   - digit codes understood by led_segment
//   - top-level state enumeration and internal operator encoding
//   - small helpers: power of ten, key -> digit, key -> operator, operator -> symbol
package calc_pkg;

  localparam logic [3:0] KEY_1   = 4'd0;
  localparam logic [3:0] KEY_2   = 4'd1;
  localparam logic [3:0] KEY_3   = 4'd2;
  localparam logic [3:0] KEY_ADD = 4'd3;
  localparam logic [3:0] KEY_4   = 4'd4;
  localparam logic [3:0] KEY_5   = 4'd5;
  localparam logic [3:0] KEY_6   = 4'd6;
  localparam logic [3:0] KEY_SUB = 4'd7;
  localparam logic [3:0] KEY_7   = 4'd8;
  localparam logic [3:0] KEY_8   = 4'd9;
  localparam logic [3:0] KEY_9   = 4'd10;
  localparam logic [3:0] KEY_MUL = 4'd11;
  localparam logic [3:0] KEY_0   = 4'd12;
  localparam logic [3:0] KEY_CLR = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_DIV = 4'd15;

  localparam logic [4:0] SEG_ADD   = 5'd10;
  localparam logic [4:0] SEG_MINUS = 5'd12;
  localparam logic [4:0] SEG_MUL   = 5'd13;
  localparam logic [4:0] SEG_DIV   = 5'd14;
  localparam logic [4:0] SEG_E     = 5'd15;
  localparam logic [4:0] SEG_BLANK = 5'd16;
  localparam logic [4:0] SEG_R     = 5'd17;

  typedef enum logic [3:0] {
    IDLE, A_IN, OP, B_IN, EXEC, DIV, CONV, SHOW, ERR
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV
  } op_e;

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic is_op_key(input logic [3:0] idx);
    return (idx == KEY_ADD) || (idx == KEY_SUB) || (idx == KEY_MUL) || (idx == KEY_DIV);
  endfunction

  function automatic logic [3:0] key_digit(input logic [3:0] idx);
    case (idx)
      KEY_1:   return 4'd1;
      KEY_2:   return 4'd2;
      KEY_3:   return 4'd3;
      KEY_4:   return 4'd4;
      KEY_5:   return 4'd5;
      KEY_6:   return 4'd6;
      KEY_7:   return 4'd7;
      KEY_8:   return 4'd8;
      KEY_9:   return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic op_e key_op(input logic [3:0] idx);
    case (idx)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_ADD;
    endcase
  endfunction

  function automatic logic [4:0] op_symbol(input op_e op);
    case (op)
      OP_SUB:  return SEG_MINUS;
      OP_MUL:  return SEG_MUL;
      OP_DIV:  return SEG_DIV;
      default: return SEG_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_div.sv
// calc_div: unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clear              abandons any division in progress (no done follows)
//   start              one-cycle request; dividend/divisor sampled with it
//   dividend, divisor  W-bit unsigned operands (divisor must be non-zero)
//   quotient           W-bit result, valid while done is high
//   done               one-cycle pulse when the last quotient bit is in
// The first quotient bit is produced on the start edge itself, so the
// W-th bit (and done) lands W-1 edges later.
module calc_div #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d, done_q, done_d;

  logic [W-1:0]  src_rem, src_quo, src_dvs, rem_step, quo_step;
  logic [W:0]    trial, diff;

  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_quo  = start ? dividend : quo_q;
    src_dvs  = start ? divisor : dvs_q;
    trial    = {src_rem, src_quo[W-1]};
    diff     = trial - {1'b0, src_dvs};
    // negative trial difference: restore, quotient bit 0
    rem_step = diff[W] ? trial[W-1:0] : diff[W-1:0];
    quo_step = {src_quo[W-2:0], ~diff[W]};

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (clear) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      rem_d = rem_step;
      quo_d = quo_step;
      dvs_d = divisor;
      cnt_d = CW'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/calc_core.sv
// calc_core: four-function signed integer calculator between keyboard and
// led_segment.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   key_pulse     one-hot key strobe (one cycle); zero / multi-hot ignored
//   seg_data      SEG_NUM 5-bit digit codes, [4:0] is the leftmost digit
//   seg_data_en   digit enables, always all ones
//   seg_dot_en    dot enables, always zero
//   busy          high in EXEC, DIV and CONV
//   err           high in ERR
// Keys are registered before decoding, so a key captured at edge N shows
// in state and display at edge N+1. The display is a register updated on
// each accepted key; results are rendered from a double-dabble BCD shift
// that runs one bit per cycle in CONV.
module calc_core
  import calc_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int SEG_NUM = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          key_pulse,
  output logic [SEG_NUM*5-1:0] seg_data,
  output logic [SEG_NUM-1:0]   seg_data_en,
  output logic [SEG_NUM-1:0]   seg_dot_en,
  output logic                 busy,
  output logic                 err
);

  localparam longint MAXV = pow10(SEG_NUM - 1) - 1;
  localparam int VW  = $clog2(MAXV + 1);
  localparam int AW  = VW + 1;
  localparam int XW  = 2 * AW;
  localparam int ND  = SEG_NUM - 1;
  localparam int BW  = 4 * ND;
  localparam int CW  = $clog2(VW + 1);
  localparam int SW  = SEG_NUM * 5;
  localparam logic [CW-1:0] CONV_LAST = CW'(VW - 1);
  localparam logic [2:0]    DIG_MAX   = 3'(DIGITS);
  localparam logic [XW-1:0] MAXV_X    = XW'(MAXV);
  localparam logic [SW-1:0] SEG_ALL_BLANK = {SEG_NUM{SEG_BLANK}};
  localparam logic [SW-1:0] SEG_ERR_PAT   = {SEG_R, SEG_R, SEG_E, {(SEG_NUM-3){SEG_BLANK}}};

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [15:0]           key_q, key_d;
  logic signed [AW-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  neg_q, neg_d, ovf_q, ovf_d, div_neg_q, div_neg_d;
  logic [VW-1:0]         sh_q, sh_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [CW-1:0]         ccnt_q, ccnt_d;
  logic [SW-1:0]         seg_q, seg_d;
  logic                  busy_q, busy_d, err_q, err_d;

  // key decode
  logic       key_valid, is_clr, is_eq, is_op, is_dig;
  logic [3:0] key_idx, dig;
  op_e        key_opv;
  logic [4:0] dig_code, key_sym;

  always_comb begin
    key_d     = key_pulse;
    key_valid = (key_q != 16'd0) && ((key_q & (key_q - 16'd1)) == 16'd0);
    key_idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (key_q[i]) key_idx = 4'(i);
    end
    is_clr   = key_valid && (key_idx == KEY_CLR);
    is_eq    = key_valid && (key_idx == KEY_EQ);
    is_op    = key_valid && is_op_key(key_idx);
    is_dig   = key_valid && !is_clr && !is_eq && !is_op;
    dig      = key_digit(key_idx);
    dig_code = {1'b0, dig};
    key_opv  = key_op(key_idx);
    key_sym  = op_symbol(key_opv);
  end

  // arithmetic at double width so sums and products never wrap before the range check
  logic signed [XW-1:0] a_x, b_x, res_x;
  logic [XW-1:0]        res_mag;
  logic                 res_ovf;
  logic [AW-1:0]        a_mag, b_mag, q_ext;
  logic [VW-1:0]        div_quo;
  logic                 div_done, div_start, div_clear, q_neg;

  always_comb begin
    a_x = {{(XW-AW){a_q[AW-1]}}, a_q};
    b_x = {{(XW-AW){b_q[AW-1]}}, b_q};
    case (op_q)
      OP_ADD:  res_x = a_x + b_x;
      OP_SUB:  res_x = a_x - b_x;
      OP_MUL:  res_x = a_x * b_x;
      default: res_x = '0;
    endcase
    res_mag = res_x[XW-1] ? -res_x : res_x;
    res_ovf = res_mag > MAXV_X;
    a_mag   = a_q[AW-1] ? -a_q : a_q;
    b_mag   = b_q[AW-1] ? -b_q : b_q;
    q_ext   = {1'b0, div_quo};
    // a zero quotient is never shown as "-0"
    q_neg   = div_neg_q && (div_quo != '0);
  end

  calc_div #(.W(VW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (div_clear),
    .start    (div_start),
    .dividend (a_mag[VW-1:0]),
    .divisor  (b_mag[VW-1:0]),
    .quotient (div_quo),
    .done     (div_done)
  );

  // one double-dabble step and the rendering of its outcome
  logic [BW-1:0] bcd_adj, bcd_step;
  logic [VW-1:0] sh_step;
  logic [SW-1:0] seg_fmt;
  int            msd;

  always_comb begin
    for (int j = 0; j < ND; j++) begin
      bcd_adj[4*j +: 4] = (bcd_q[4*j +: 4] >= 4'd5) ? bcd_q[4*j +: 4] + 4'd3 : bcd_q[4*j +: 4];
    end
    bcd_step = {bcd_adj[BW-2:0], sh_q[VW-1]};
    sh_step  = {sh_q[VW-2:0], 1'b0};

    msd = 0;
    for (int j = 0; j < ND; j++) begin
      if (bcd_step[4*j +: 4] != 4'd0) msd = j;
    end
    seg_fmt = SEG_ALL_BLANK;
    for (int j = 0; j < ND; j++) begin
      if (j <= msd) seg_fmt[(SEG_NUM-1-j)*5 +: 5] = {1'b0, bcd_step[4*j +: 4]};
    end
    if (neg_q) seg_fmt[(SEG_NUM-2-msd)*5 +: 5] = SEG_MINUS;
  end

  // next-state / datapath
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    div_neg_d = div_neg_q;
    sh_d      = sh_q;
    bcd_d     = bcd_q;
    ccnt_d    = ccnt_q;
    seg_d     = seg_q;
    div_start = 1'b0;
    div_clear = 1'b0;

    if (is_clr) begin
      state_d   = IDLE;
      a_d       = '0;
      b_d       = '0;
      r_d       = '0;
      cnt_d     = '0;
      seg_d     = SEG_ALL_BLANK;
      div_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE, SHOW: begin
          if (is_dig) begin
            a_d     = AW'(dig);
            cnt_d   = 3'd1;
            seg_d   = {dig_code, {(SEG_NUM-1){SEG_BLANK}}};
            state_d = A_IN;
          end else if (is_op && state_q == SHOW) begin
            a_d     = r_q;
            op_d    = key_opv;
            seg_d   = {seg_q[SW-1:5], key_sym};
            state_d = OP;
          end
        end
        A_IN: begin
          if (is_dig && cnt_q < DIG_MAX) begin
            a_d   = a_q * AW'(10) + AW'(dig);
            cnt_d = cnt_q + 3'd1;
            // a lone leading zero is replaced rather than shifted left
            seg_d = (a_q == '0) ? {dig_code, {(SEG_NUM-1){SEG_BLANK}}}
                                : {dig_code, seg_q[SW-1:5]};
          end else if (is_op) begin
            op_d    = key_opv;
            seg_d   = {seg_q[SW-1:5], key_sym};
            state_d = OP;
          end
        end
        OP: begin
          if (is_op) begin
            op_d  = key_opv;
            seg_d = {seg_q[SW-1:5], key_sym};
          end else if (is_dig) begin
            b_d     = AW'(dig);
            cnt_d   = 3'd1;
            seg_d   = {dig_code, {(SEG_NUM-2){SEG_BLANK}}, op_symbol(op_q)};
            state_d = B_IN;
          end
        end
        B_IN: begin
          if (is_dig && cnt_q < DIG_MAX) begin
            b_d   = b_q * AW'(10) + AW'(dig);
            cnt_d = cnt_q + 3'd1;
            seg_d = (b_q == '0) ? {dig_code, {(SEG_NUM-2){SEG_BLANK}}, op_symbol(op_q)}
                                : {dig_code, seg_q[SW-1:10], op_symbol(op_q)};
          end else if (is_eq) begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (op_q == OP_DIV) begin
            if (b_q == '0) begin
              seg_d   = SEG_ERR_PAT;
              state_d = ERR;
            end else begin
              div_start = 1'b1;
              div_neg_d = a_q[AW-1] ^ b_q[AW-1];
              state_d   = DIV;
            end
          end else begin
            r_d     = res_x[AW-1:0];
            neg_d   = res_x[XW-1];
            ovf_d   = res_ovf;
            sh_d    = res_mag[VW-1:0];
            bcd_d   = '0;
            ccnt_d  = '0;
            state_d = CONV;
          end
        end
        DIV: begin
          if (div_done) begin
            r_d     = q_neg ? -q_ext : q_ext;
            neg_d   = q_neg;
            ovf_d   = 1'b0;
            sh_d    = div_quo;
            bcd_d   = '0;
            ccnt_d  = '0;
            state_d = CONV;
          end
        end
        CONV: begin
          if (ccnt_q == '0 && ovf_q) begin
            seg_d   = SEG_ERR_PAT;
            state_d = ERR;
          end else begin
            bcd_d  = bcd_step;
            sh_d   = sh_step;
            ccnt_d = ccnt_q + CW'(1);
            if (ccnt_q == CONV_LAST) begin
              seg_d   = seg_fmt;
              state_d = SHOW;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d == EXEC) || (state_d == DIV) || (state_d == CONV);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      key_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      div_neg_q <= 1'b0;
      sh_q      <= '0;
      bcd_q     <= '0;
      ccnt_q    <= '0;
      seg_q     <= SEG_ALL_BLANK;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      key_q     <= key_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      div_neg_q <= div_neg_d;
      sh_q      <= sh_d;
      bcd_q     <= bcd_d;
      ccnt_q    <= ccnt_d;
      seg_q     <= seg_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign seg_data    = seg_q;
  assign seg_data_en = '1;
  assign seg_dot_en  = '0;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: two calculator instances (2-digit/8-segment and
// 4-digit/9-segment) driven by key presses; results, displays, busy length
// and error flag are compared against an arithmetic model of the calculator.
module tb_calc_core;

  localparam int SEG0 = 8;
  localparam int DIG0 = 2;
  localparam int SEG1 = 9;
  localparam int DIG1 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]         key0 = '0, key1 = '0;
  logic [SEG0*5-1:0]   seg0;
  logic [SEG0-1:0]     en0, dot0;
  logic [SEG1*5-1:0]   seg1;
  logic [SEG1-1:0]     en1, dot1;
  logic                busy0, err0, busy1, err1;

  calc_core #(.DIGITS(DIG0), .SEG_NUM(SEG0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .key_pulse(key0), .seg_data(seg0),
    .seg_data_en(en0), .seg_dot_en(dot0), .busy(busy0), .err(err0)
  );

  calc_core #(.DIGITS(DIG1), .SEG_NUM(SEG1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .key_pulse(key1), .seg_data(seg1),
    .seg_data_en(en1), .seg_dot_en(dot1), .busy(busy1), .err(err1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int dkey[10] = '{12, 0, 1, 2, 4, 5, 6, 8, 9, 10};
  int opk[4]   = '{3, 7, 11, 15};
  int opsym[4] = '{10, 12, 13, 14};

  // ---------------- reference model helpers ----------------
  function automatic int segn_of(input int which);
    return (which == 0) ? SEG0 : SEG1;
  endfunction

  function automatic longint maxv_of(input int segn);
    longint m = 1;
    for (int i = 0; i < segn - 1; i++) m = m * 10;
    return m - 1;
  endfunction

  function automatic int vw_of(input int segn);
    longint m = maxv_of(segn);
    int v = 0;
    while ((64'd1 << v) <= m) v++;
    return v;
  endfunction

  function automatic logic [63:0] disp_blank(input int segn);
    logic [63:0] d = '0;
    for (int i = 0; i < segn; i++) d[i*5 +: 5] = 5'd16;
    return d;
  endfunction

  // decimal value written right-aligned, minus just left of the top digit
  function automatic logic [63:0] disp_val(input longint v, input int segn);
    logic [63:0] d = disp_blank(segn);
    longint m = (v < 0) ? -v : v;
    int pos = segn - 1;
    do begin
      d[pos*5 +: 5] = 5'(m % 10);
      m = m / 10;
      pos--;
    end while (m > 0);
    if (v < 0 && pos >= 0) d[pos*5 +: 5] = 5'd12;
    return d;
  endfunction

  function automatic logic [63:0] disp_err(input int segn);
    logic [63:0] d = disp_blank(segn);
    d[(segn-3)*5 +: 5] = 5'd15;
    d[(segn-2)*5 +: 5] = 5'd17;
    d[(segn-1)*5 +: 5] = 5'd17;
    return d;
  endfunction

  function automatic logic [63:0] with_sym(input logic [63:0] d, input int sym);
    logic [63:0] r = d;
    r[4:0] = 5'(sym);
    return r;
  endfunction

  function automatic logic [63:0] seg_of(input int which);
    return (which == 0) ? 64'(seg0) : 64'(seg1);
  endfunction

  function automatic logic busy_of(input int which);
    return (which == 0) ? busy0 : busy1;
  endfunction

  function automatic logic err_of(input int which);
    return (which == 0) ? err0 : err1;
  endfunction

  // ---------------- driver tasks ----------------
  // returns one negedge after the edge following the sampling edge
  task automatic press_raw(input int which, input logic [15:0] val);
    @(negedge clk);
    if (which == 0) key0 = val; else key1 = val;
    @(negedge clk);
    key0 = '0;
    key1 = '0;
    @(negedge clk);
  endtask

  task automatic press(input int which, input int idx);
    press_raw(which, 16'd1 << idx);
  endtask

  task automatic type_num(input int which, input longint v);
    int ds[$];
    longint m = v;
    do begin
      ds.push_front(int'(m % 10));
      m = m / 10;
    end while (m > 0);
    foreach (ds[i]) press(which, dkey[ds[i]]);
  endtask

  // '=' then count busy samples (bounded)
  task automatic do_eq(input int which, output int cyc);
    press(which, 14);
    cyc = 0;
    while (busy_of(which) && cyc <= 400) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // one operation; a is typed when a_typed, otherwise it is the shown result
  task automatic calc(input int which, input longint a, input bit a_typed, input int opi,
                      input longint b, output longint r, output bit e);
    int segn = segn_of(which);
    int vw   = vw_of(segn);
    int cyc, exp_busy;
    r = 0;
    e = 1'b0;
    if (a_typed) begin
      type_num(which, a);
      check("a_disp", seg_of(which), disp_val(a, segn));
    end
    press(which, opk[opi]);
    check("op_disp", seg_of(which), with_sym(disp_val(a, segn), opsym[opi]));
    type_num(which, b);
    check("b_disp", seg_of(which), with_sym(disp_val(b, segn), opsym[opi]));
    case (opi)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      default: if (b == 0) e = 1'b1; else r = a / b;
    endcase
    if (opi == 3) exp_busy = e ? 1 : 2 * vw + 1;
    else if (r > maxv_of(segn) || -r > maxv_of(segn)) begin
      e = 1'b1;
      exp_busy = 2;
    end else exp_busy = vw + 1;
    exp_q.push_back(e ? disp_err(segn) : disp_val(r, segn));
    do_eq(which, cyc);
    check("busy_cycles", 64'(cyc), 64'(exp_busy));
    check("err_flag", 64'(err_of(which)), 64'(e));
    check("result_disp", seg_of(which), exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    longint r, a, b;
    bit e;
    int opi, cyc;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_seg0", seg_of(0), disp_blank(SEG0));
    check("rst_seg1", seg_of(1), disp_blank(SEG1));
    check("rst_en0", 64'(en0), 64'(8'hff));
    check("rst_dot0", 64'(dot0), 64'd0);
    check("rst_en1", 64'(en1), 64'(9'h1ff));
    check("rst_dot1", 64'(dot1), 64'd0);
    check("rst_busy", 64'({busy0, busy1}), 64'd0);
    check("rst_err", 64'({err0, err1}), 64'd0);

    // 12+34
    calc(0, 12, 1, 0, 34, r, e);
    // 5-17, then chain +2
    press(0, 13);
    calc(0, 5, 1, 1, 17, r, e);
    calc(0, r, 0, 0, 2, r, e);
    // 99*99
    press(0, 13);
    calc(0, 99, 1, 2, 99, r, e);
    // third digit beyond DIGITS ignored
    press(0, 13);
    press(0, dkey[1]); press(0, dkey[2]); press(0, dkey[3]);
    check("digit_limit", seg_of(0), disp_val(12, SEG0));
    // invalid (two-hot) and empty key strobes are ignored
    press_raw(0, 16'h0011);
    press_raw(0, 16'h0000);
    check("multi_hot_ignored", seg_of(0), disp_val(12, SEG0));

    // divide by zero, ERR accepts only C
    press(0, 13);
    calc(0, 7, 1, 3, 0, r, e);
    press(0, dkey[5]);
    press(0, opk[0]);
    press(0, 14);
    check("err_hold_disp", seg_of(0), disp_err(SEG0));
    check("err_hold_flag", 64'(err0), 64'd1);
    press(0, 13);
    check("clr_err_disp", seg_of(0), disp_blank(SEG0));
    check("clr_err_flag", 64'({err0, busy0}), 64'd0);

    // division, positive and negative
    calc(0, 9, 1, 3, 2, r, e);
    press(0, 13);
    calc(0, 1, 1, 1, 9, r, e);
    calc(0, r, 0, 3, 3, r, e);

    // C in the middle of a division
    press(0, 13);
    type_num(0, 9);
    press(0, opk[3]);
    type_num(0, 2);
    press(0, 14);
    check("div_busy_started", 64'(busy0), 64'd1);
    repeat (5) @(negedge clk);
    press(0, 13);
    check("mid_div_clr_disp", seg_of(0), disp_blank(SEG0));
    check("mid_div_clr_busy", 64'(busy0), 64'd0);
    repeat (2 * vw_of(SEG0) + 4) @(negedge clk);
    check("mid_div_stays_blank", seg_of(0), disp_blank(SEG0));
    check("mid_div_stays_idle", 64'({busy0, err0}), 64'd0);

    // wide instance: 9999*9999, then overflow on chaining
    press(1, 13);
    calc(1, 9999, 1, 2, 9999, r, e);
    calc(1, r, 0, 2, 99, r, e);
    press(1, 13);
    check("wide_clr", seg_of(1), disp_blank(SEG1));

    // randomized chains on the narrow instance
    for (int it = 0; it < 12; it++) begin
      press(0, 13);
      a   = $urandom_range(0, 99);
      opi = $urandom_range(0, 3);
      b   = (it % 5 == 4) ? 0 : $urandom_range(0, 99);
      calc(0, a, 1, opi, b, r, e);
      for (int c = 0; c < 3 && !e; c++) begin
        opi = $urandom_range(0, 3);
        b   = $urandom_range(0, 99);
        calc(0, r, 0, opi, b, r, e);
      end
    end

    // randomized chains on the wide instance
    for (int it = 0; it < 5; it++) begin
      press(1, 13);
      a   = $urandom_range(0, 9999);
      opi = $urandom_range(0, 3);
      b   = $urandom_range(1, 9999);
      calc(1, a, 1, opi, b, r, e);
      for (int c = 0; c < 2 && !e; c++) begin
        opi = $urandom_range(0, 3);
        b   = $urandom_range(0, 9999);
        calc(1, r, 0, opi, b, r, e);
      end
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
